// File: rtl/dff_pipe_pkg.sv
// Shared limits and defaults for the dff_pipe register pipeline.
package dff_pipe_pkg;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 64;
  localparam int unsigned DEPTH_MIN = 1;
  localparam int unsigned DEPTH_MAX = 16;

  localparam logic [WIDTH_MAX-1:0] RESET_VAL_DEFAULT = '0;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH data bits plus a valid bit, with sync reset,
// flush and advance enable (rst > clr > en).
module dff_stage
  import dff_pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = RESET_VAL_DEFAULT[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clr) begin
      data_d  = RESET_VAL;
      valid_d = 1'b0;
    end else if (en) begin
      data_d  = data_i;
      valid_d = valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RESET_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage enabled register pipeline with valid tracking and flush.
// Optional macro DFF_PIPE_LOCKSTEP_EN adds a compared shadow pipeline.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = RESET_VAL_DEFAULT[WIDTH-1:0]
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 busy
`ifdef DFF_PIPE_LOCKSTEP_EN
  ,
  input  logic                 inject,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  // Index 0 is the pipeline input; index k is the output of stage k-1.
  logic [DEPTH:0][WIDTH-1:0] m_data;
  logic [DEPTH:0]            m_valid;

  assign m_data[0]  = din;
  assign m_valid[0] = din_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_main
    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .data_i  (m_data[k]),
      .valid_i (m_valid[k]),
      .data_o  (m_data[k+1]),
      .valid_o (m_valid[k+1])
    );
  end

  assign dout       = m_data[DEPTH];
  assign dout_valid = m_valid[DEPTH];
  assign busy       = |m_valid[DEPTH:1];

`ifdef DFF_PIPE_LOCKSTEP_EN
  logic [DEPTH:0][WIDTH-1:0] s_data;
  logic [DEPTH:0]            s_valid;
  logic                      diff;

  assign s_data[0]  = din ^ WIDTH'(inject);
  assign s_valid[0] = din_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_shadow
    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .data_i  (s_data[k]),
      .valid_i (s_valid[k]),
      .data_o  (s_data[k+1]),
      .valid_o (s_valid[k+1])
    );
  end

  assign diff = (s_data[DEPTH:1] != m_data[DEPTH:1]) ||
                (s_valid[DEPTH:1] != m_valid[DEPTH:1]);

  logic                 mismatch_q, mismatch_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Only rst clears the error record; clr resynchronises the stages alone.
  always_comb begin
    mismatch_d = mismatch_q | diff;
    err_cnt_d  = err_cnt_q;
    if (diff && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: a default instance (DEPTH=4, RESET_VAL=0)
// and a DEPTH=1, RESET_VAL=8'h3C instance share one stimulus stream.
module tb_dff_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, clr, din_valid;
  logic [7:0] din;
  logic [7:0] dout0, dout1;
  logic       dv0, dv1, busy0, busy1;
`ifdef DFF_PIPE_LOCKSTEP_EN
  logic       inject;
  logic       mm0, mm1;
  logic [7:0] ec0, ec1;
`endif

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(dout0), .dout_valid(dv0), .busy(busy0)
`ifdef DFF_PIPE_LOCKSTEP_EN
    , .inject(inject), .mismatch(mm0), .err_cnt(ec0)
`endif
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .din(din), .din_valid(din_valid),
    .dout(dout1), .dout_valid(dv1), .busy(busy1)
`ifdef DFF_PIPE_LOCKSTEP_EN
    , .inject(inject), .mismatch(mm1), .err_cnt(ec1)
`endif
  );

  typedef struct {
    logic [7:0]  data;
    int unsigned due;
  } ent_t;

  ent_t        sb0[$];
  ent_t        sb1[$];
  int unsigned en_cnt   = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, exp);
  endtask

  // Drive one cycle of inputs, clock it, then score both instances.
  task automatic cyc(input logic r, input logic c, input logic e, input logic v,
                     input logic [7:0] d);
    rst = r; clr = c; en = e; din_valid = v; din = d;
    if (r || c) begin
      sb0.delete();
      sb1.delete();
    end else if (e && v) begin
      sb0.push_back('{d, en_cnt + 4});
      sb1.push_back('{d, en_cnt + 1});
    end
    @(posedge clk);
    if (!r && !c && e) en_cnt++;
    #1;
    while (sb0.size() > 0 && sb0[0].due < en_cnt) void'(sb0.pop_front());
    while (sb1.size() > 0 && sb1[0].due < en_cnt) void'(sb1.pop_front());

    if (sb0.size() > 0 && sb0[0].due == en_cnt) begin
      check_eq("d4_valid", dv0, 1'b1);
      check_eq("d4_dout", dout0, sb0[0].data);
    end else begin
      check_eq("d4_valid", dv0, 1'b0);
    end
    check_eq("d4_busy", busy0, sb0.size() > 0);

    if (sb1.size() > 0 && sb1[0].due == en_cnt) begin
      check_eq("d1_valid", dv1, 1'b1);
      check_eq("d1_dout", dout1, sb1[0].data);
    end else begin
      check_eq("d1_valid", dv1, 1'b0);
    end
    check_eq("d1_busy", busy1, sb1.size() > 0);

    if (r || c) begin
      check_eq("d4_rstval", dout0, 8'h00);
      check_eq("d1_rstval", dout1, 8'h3C);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; din_valid = 1'b0; din = '0;
`ifdef DFF_PIPE_LOCKSTEP_EN
    inject = 1'b0;
`endif

    // Reset held 2 cycles against an active valid input.
    cyc(1, 0, 1, 1, 8'hFF);
    cyc(1, 0, 1, 1, 8'hFF);
    cyc(0, 0, 1, 0, 8'h00);

    // Single-entry latency.
    cyc(0, 0, 1, 1, 8'hA5);
    for (int unsigned i = 0; i < 6; i++) cyc(0, 0, 1, 0, 8'h00);

    // Stall of 3 cycles after the second value.
    cyc(0, 0, 1, 1, 8'h01);
    cyc(0, 0, 1, 1, 8'h02);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, i[0], 8'hEE);
    cyc(0, 0, 1, 1, 8'h03);
    cyc(0, 0, 1, 1, 8'h04);
    for (int unsigned i = 0; i < 6; i++) cyc(0, 0, 1, 0, 8'h00);

    // Flush with 3 in flight; the entering value is discarded.
    cyc(0, 0, 1, 1, 8'h11);
    cyc(0, 0, 1, 1, 8'h22);
    cyc(0, 0, 1, 1, 8'h33);
    cyc(0, 1, 1, 1, 8'h77);
    for (int unsigned i = 0; i < 5; i++) cyc(0, 0, 1, 0, 8'h00);

    // Reset and flush together, mid-stream.
    cyc(0, 0, 1, 1, 8'h5A);
    cyc(1, 1, 1, 1, 8'h99);
    for (int unsigned i = 0; i < 5; i++) cyc(0, 0, 1, 0, 8'h00);

    // Randomised traffic with occasional flush and reset.
    for (int unsigned i = 0; i < 120; i++) begin
      cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)));
    end
    for (int unsigned i = 0; i < 6; i++) cyc(0, 0, 1, 0, 8'h00);

`ifdef DFF_PIPE_LOCKSTEP_EN
    cyc(1, 0, 1, 0, 8'h00);
    check_eq("ls_mm_rst", mm0, 1'b0);
    check_eq("ls_ec_rst", ec0, 8'd0);
    inject = 1'b1;
    cyc(0, 0, 1, 1, 8'hC3);
    inject = 1'b0;
    check_eq("ls_mm_edge", mm0, 1'b0);
    cyc(0, 0, 1, 1, 8'h3C);
    check_eq("ls_mm_set", mm0, 1'b1);
    check_eq("ls1_mm_set", mm1, 1'b1);
    for (int unsigned i = 0; i < 6; i++) cyc(0, 0, 1, 1, 8'(i + 8'h40));
    check_eq("ls_ec_drain", ec0, 8'd4);
    check_eq("ls1_ec_drain", ec1, 8'd1);
    cyc(0, 1, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    check_eq("ls_mm_clr", mm0, 1'b1);
    check_eq("ls_ec_clr", ec0, 8'd4);
    cyc(1, 0, 1, 0, 8'h00);
    check_eq("ls_mm_cleared", mm0, 1'b0);
    check_eq("ls_ec_cleared", ec0, 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
